// File: rtl/ram_dp_pkg.sv
// rtl/ram_dp_pkg.sv - shared widths, RAM depth and op encoding for the dual-port RAM access controller
package ram_dp_pkg;
  localparam int   DW_DEF    = 8;
  localparam int   AW_DEF    = 6;
  localparam int   RAM_DEPTH = 2 ** AW_DEF;
  localparam logic OP_RD     = 1'b0;
  localparam logic OP_WR     = 1'b1;
endpackage

// File: rtl/ram_dp_conflict_arb.sv
// rtl/ram_dp_conflict_arb.sv - same-address conflict detection; RAM_DP_ACCESS_CTRL_RR_ARB_EN adds a round-robin pointer
module ram_dp_conflict_arb
  import ram_dp_pkg::*;
#(
  parameter int AW = AW_DEF
) (
`ifdef RAM_DP_ACCESS_CTRL_RR_ARB_EN
  input  logic          clk,
  input  logic          rst_n,
`endif
  input  logic          req_a,
  input  logic          wr_a,
  input  logic [AW-1:0] addr_a,
  input  logic          req_b,
  input  logic          wr_b,
  input  logic [AW-1:0] addr_b,
  output logic          stall_a,
  output logic          stall_b
);

  logic conflict;

  // Two reads of one address are safe; any write to a shared address is not.
  assign conflict = req_a && req_b && (addr_a == addr_b) &&
                    ((wr_a == OP_WR) || (wr_b == OP_WR));

`ifdef RAM_DP_ACCESS_CTRL_RR_ARB_EN
  logic ptr_q;
  logic ptr_d;

  // ptr_q names the winner (0 = A); after a conflict it hands priority to the loser.
  always_comb begin
    ptr_d = ptr_q;
    if (conflict) ptr_d = ~ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  assign stall_a = conflict && ptr_q;
  assign stall_b = conflict && !ptr_q;
`else
  assign stall_a = 1'b0;
  assign stall_b = conflict;
`endif

endmodule

// File: rtl/ram_dp_access_ctrl.sv
// rtl/ram_dp_access_ctrl.sv - two-client issue registers and read-valid pipelines for a true dual-port RAM; option RAM_DP_ACCESS_CTRL_RR_ARB_EN
module ram_dp_access_ctrl
  import ram_dp_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          wr_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          ack_a,
  output logic [DW-1:0] rdata_a,
  output logic          rvalid_a,
  input  logic          req_b,
  input  logic          wr_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_b,
  output logic [DW-1:0] rdata_b,
  output logic          rvalid_b,
  output logic [AW-1:0] ram_addr_a,
  output logic [DW-1:0] ram_data_a,
  output logic          ram_we_a,
  input  logic [DW-1:0] ram_q_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_b,
  output logic          ram_we_b,
  input  logic [DW-1:0] ram_q_b
);

  logic          stall_a, stall_b;
  logic          acc_a, acc_b;
  logic          we_a_d, we_b_d, rd_a_d, rd_b_d;
  logic [AW-1:0] addr_a_q, addr_b_q;
  logic [DW-1:0] data_a_q, data_b_q;
  logic          we_a_q, we_b_q;
  logic          rd_a_q, rd_b_q;
  logic          rvalid_a_q, rvalid_b_q;

  ram_dp_conflict_arb #(.AW(AW)) u_arb (
`ifdef RAM_DP_ACCESS_CTRL_RR_ARB_EN
    .clk     (clk),
    .rst_n   (rst_n),
`endif
    .req_a   (req_a),
    .wr_a    (wr_a),
    .addr_a  (addr_a),
    .req_b   (req_b),
    .wr_b    (wr_b),
    .addr_b  (addr_b),
    .stall_a (stall_a),
    .stall_b (stall_b)
  );

  // Gating with rst_n keeps the handshake quiet while the array side is held in reset.
  assign ack_a  = req_a && !stall_a && rst_n;
  assign ack_b  = req_b && !stall_b && rst_n;
  assign acc_a  = req_a && ack_a;
  assign acc_b  = req_b && ack_b;
  assign we_a_d = acc_a && (wr_a == OP_WR);
  assign we_b_d = acc_b && (wr_b == OP_WR);
  assign rd_a_d = acc_a && (wr_a == OP_RD);
  assign rd_b_d = acc_b && (wr_b == OP_RD);

  // rd_x_q marks the cycle the RAM sees the address; rvalid_x_q the cycle its q is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a_q   <= '0;
      data_a_q   <= '0;
      we_a_q     <= 1'b0;
      rd_a_q     <= 1'b0;
      rvalid_a_q <= 1'b0;
      addr_b_q   <= '0;
      data_b_q   <= '0;
      we_b_q     <= 1'b0;
      rd_b_q     <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      we_a_q     <= we_a_d;
      rd_a_q     <= rd_a_d;
      rvalid_a_q <= rd_a_q;
      if (acc_a) begin
        addr_a_q <= addr_a;
        data_a_q <= wdata_a;
      end
      we_b_q     <= we_b_d;
      rd_b_q     <= rd_b_d;
      rvalid_b_q <= rd_b_q;
      if (acc_b) begin
        addr_b_q <= addr_b;
        data_b_q <= wdata_b;
      end
    end
  end

  assign ram_addr_a = addr_a_q;
  assign ram_data_a = data_a_q;
  assign ram_we_a   = we_a_q;
  assign ram_addr_b = addr_b_q;
  assign ram_data_b = data_b_q;
  assign ram_we_b   = we_b_q;
  assign rvalid_a   = rvalid_a_q;
  assign rvalid_b   = rvalid_b_q;
  assign rdata_a    = ram_q_a;
  assign rdata_b    = ram_q_b;

endmodule

// File: tb/tb_ram_dp_access_ctrl.sv
// tb/tb_ram_dp_access_ctrl.sv - table-driven scoreboard bench for ram_dp_access_ctrl with a behavioural 64x8 dual-port RAM
module tb_ram_dp_access_ctrl;
  import ram_dp_pkg::*;

  logic       clk, rst_n;
  logic       req_a, wr_a, req_b, wr_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       ack_a, ack_b, rvalid_a, rvalid_b;
  logic [7:0] rdata_a, rdata_b;
  logic [5:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b;
  logic       ram_we_a, ram_we_b;

  ram_dp_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a), .ram_q_a(ram_q_a),
    .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b)
  );

  // Write-first true dual-port RAM with registered read.
  logic [7:0] mem [0:RAM_DEPTH-1];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    ram_q_a <= ram_we_a ? ram_data_a : mem[ram_addr_a];
    ram_q_b <= ram_we_b ? ram_data_b : mem[ram_addr_b];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ra; logic wa; logic [5:0] aa; logic [7:0] da;
    logic rb; logic wb; logic [5:0] ab; logic [7:0] db;
    logic ea; logic eb;
  } vec_t;

  typedef struct { int stamp; logic [7:0] data; } exp_t;

  exp_t       q_a[$], q_b[$];
  logic [7:0] ref_mem [0:RAM_DEPTH-1];
  int         checks = 0, failures = 0, cyc = 0;
  logic       ex_acc_a, ex_acc_b, ex_we_a, ex_we_b;
  logic [5:0] ex_addr_a, ex_addr_b;
  logic [7:0] ex_data_a, ex_data_b;
  vec_t       tbl [0:11];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic check_outputs();
    exp_t e;
    chk("ram_we_a", ram_we_a, ex_we_a);
    chk("ram_we_b", ram_we_b, ex_we_b);
    if (ex_acc_a) chk("ram_addr_a", ram_addr_a, ex_addr_a);
    if (ex_acc_b) chk("ram_addr_b", ram_addr_b, ex_addr_b);
    if (ex_we_a) chk("ram_data_a", ram_data_a, ex_data_a);
    if (ex_we_b) chk("ram_data_b", ram_data_b, ex_data_b);
    if (rvalid_a) begin
      if (q_a.size() == 0) chk("rvalid_a_spurious", rvalid_a, 0);
      else begin
        e = q_a.pop_front();
        chk("rdata_a", rdata_a, e.data);
        chk("rvalid_a_latency", cyc - e.stamp, 2);
      end
    end else if (q_a.size() != 0 && q_a[0].stamp + 2 <= cyc) begin
      chk("rvalid_a_missing", rvalid_a, 1);
      void'(q_a.pop_front());
    end
    if (rvalid_b) begin
      if (q_b.size() == 0) chk("rvalid_b_spurious", rvalid_b, 0);
      else begin
        e = q_b.pop_front();
        chk("rdata_b", rdata_b, e.data);
        chk("rvalid_b_latency", cyc - e.stamp, 2);
      end
    end else if (q_b.size() != 0 && q_b[0].stamp + 2 <= cyc) begin
      chk("rvalid_b_missing", rvalid_b, 1);
      void'(q_b.pop_front());
    end
  endtask

  // Drive at negedge, sample ack just before the edge, apply the model, check after the edge.
  task automatic drive_and_sample(input vec_t v);
    logic acc_a, acc_b;
    req_a = v.ra; wr_a = v.wa; addr_a = v.aa; wdata_a = v.da;
    req_b = v.rb; wr_b = v.wb; addr_b = v.ab; wdata_b = v.db;
    #4;
    chk("ack_a", ack_a, v.ea);
    chk("ack_b", ack_b, v.eb);
    acc_a = req_a && ack_a;
    acc_b = req_b && ack_b;
    if (acc_a && !v.wa) q_a.push_back('{cyc, ref_mem[v.aa]});
    if (acc_b && !v.wb) q_b.push_back('{cyc, ref_mem[v.ab]});
    if (acc_a && v.wa) ref_mem[v.aa] = v.da;
    if (acc_b && v.wb) ref_mem[v.ab] = v.db;
    ex_acc_a = acc_a; ex_we_a = acc_a && v.wa; ex_addr_a = v.aa; ex_data_a = v.da;
    ex_acc_b = acc_b; ex_we_b = acc_b && v.wb; ex_addr_b = v.ab; ex_data_b = v.db;
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic step(input vec_t v);
    drive_and_sample(v);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('{0,0,6'd0,8'd0, 0,0,6'd0,8'd0, 0,0});
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    q_a.delete(); q_b.delete();
    ex_acc_a = 0; ex_acc_b = 0; ex_we_a = 0; ex_we_b = 0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) ref_mem[i] = 8'h00;
    ex_acc_a = 0; ex_acc_b = 0; ex_we_a = 0; ex_we_b = 0;
    ex_addr_a = 0; ex_addr_b = 0; ex_data_a = 0; ex_data_b = 0;
    rst_n = 1'b0;
    req_a = 1'b1; wr_a = 1'b0; addr_a = 6'd3; wdata_a = 8'h00;
    req_b = 1'b1; wr_b = 1'b1; addr_b = 6'd4; wdata_b = 8'h99;
    #2;
    chk("rst_ack_a", ack_a, 0);
    chk("rst_ack_b", ack_b, 0);
    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_rvalid_b", rvalid_b, 0);
    chk("rst_we_a", ram_we_a, 0);
    chk("rst_we_b", ram_we_b, 0);
    chk("rst_addr", {ram_addr_a, ram_addr_b}, 0);
    chk("rst_data", {ram_data_a, ram_data_b}, 0);
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0]  = '{1,1,6'd5,8'h3C,  0,0,6'd0,8'h00,  1,0};
    tbl[1]  = '{1,0,6'd5,8'h00,  0,0,6'd0,8'h00,  1,0};
    tbl[2]  = '{1,1,6'd1,8'h11,  1,1,6'd2,8'h22,  1,1};
    tbl[3]  = '{1,0,6'd1,8'h00,  1,0,6'd2,8'h00,  1,1};
    tbl[4]  = '{1,0,6'd2,8'h00,  1,0,6'd1,8'h00,  1,1};
    tbl[5]  = '{1,1,6'd7,8'hAA,  1,1,6'd7,8'hBB,  1,0};
    tbl[6]  = '{0,0,6'd0,8'h00,  1,1,6'd7,8'hBB,  0,1};
    tbl[7]  = '{1,0,6'd7,8'h00,  1,0,6'd7,8'h00,  1,1};
    tbl[8]  = '{1,1,6'd31,8'h5A, 1,1,6'd30,8'hC3, 1,1};
    tbl[9]  = '{1,0,6'd31,8'h00, 1,0,6'd30,8'h00, 1,1};
    tbl[10] = '{0,0,6'd0,8'h00,  0,0,6'd0,8'h00,  0,0};
    tbl[11] = '{0,0,6'd0,8'h00,  0,0,6'd0,8'h00,  0,0};
    for (int i = 0; i < 12; i++) step(tbl[i]);
    idle(2);

    // Reset in the middle of a read burst, with a write sitting on port B's pins.
    step('{1,0,6'd5,8'h00, 1,0,6'd1,8'h00, 1,1});
    step('{1,0,6'd5,8'h00, 1,0,6'd1,8'h00, 1,1});
    drive_and_sample('{1,0,6'd5,8'h00, 1,1,6'd3,8'h44, 1,1});
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid_a", rvalid_a, 0);
    chk("midrst_rvalid_b", rvalid_b, 0);
    chk("midrst_we_b", ram_we_b, 0);
    chk("midrst_ack_a", ack_a, 0);
    q_a.delete(); q_b.delete();
    ex_acc_a = 0; ex_acc_b = 0; ex_we_a = 0; ex_we_b = 0;
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Read/write conflict: A's read of the old value goes first, B's write follows.
    step('{1,1,6'd9,8'h05, 0,0,6'd0,8'h00, 1,0});
    step('{1,0,6'd9,8'h00, 1,1,6'd9,8'h66, 1,0});
    step('{0,0,6'd0,8'h00, 1,1,6'd9,8'h66, 0,1});
    step('{1,0,6'd9,8'h00, 0,0,6'd0,8'h00, 1,0});
    idle(3);

    reset_pulse();
`ifdef RAM_DP_ACCESS_CTRL_RR_ARB_EN
    step('{1,1,6'd12,8'hA1, 1,1,6'd12,8'hB1, 1,0});
    step('{1,1,6'd12,8'hA2, 1,1,6'd12,8'hB1, 0,1});
    step('{1,1,6'd12,8'hA2, 1,1,6'd12,8'hB2, 1,0});
    step('{1,1,6'd12,8'hA3, 1,1,6'd12,8'hB2, 0,1});
    step('{1,1,6'd12,8'hA3, 0,0,6'd0,8'h00,  1,0});
`else
    step('{1,1,6'd12,8'hA1, 1,1,6'd12,8'hB1, 1,0});
    step('{1,1,6'd12,8'hA2, 1,1,6'd12,8'hB1, 1,0});
    step('{0,0,6'd0,8'h00,  1,1,6'd12,8'hB1, 0,1});
`endif
    step('{1,0,6'd12,8'h00, 1,0,6'd12,8'h00, 1,1});
    idle(3);

    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
